rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-003 The block SHALL have parameter NUM_REGS, default 32, meaning number of architectural registers.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports alu_wb_valid_i (in, 1), alu_wb_addr_i (in, ADDR_W) and alu_wb_data_i (in, DATA_W): the ALU writeback request.
REQ-007 The block SHALL have port alu_wb_ready_o, output, 1 bit: the ALU request is accepted this cycle.
REQ-008 The block SHALL have ports lsu_wb_valid_i (in, 1), lsu_wb_addr_i (in, ADDR_W) and lsu_wb_data_i (in, DATA_W): the load-unit writeback request.
REQ-009 The block SHALL have port lsu_wb_ready_o, output, 1 bit: the LSU request is accepted this cycle.
REQ-010 The block SHALL have port arb2rf_rd_wr_req_o, output, 1 bit: register-file write enable.
REQ-011 The block SHALL have ports arb2rf_rd_addr_o (out, ADDR_W) and arb2rf_rd_data_o (out, DATA_W): register-file write address and data.
REQ-012 The block SHALL have port init_done_o, output, 1 bit: the register file is initialised and the arbiter is serving requests.

Function
REQ-013 The FSM SHALL have states CLEAR and RUN.
REQ-014 In CLEAR, both ready outputs SHALL be 0.
REQ-015 In RUN, a transfer SHALL occur on a requester when its valid and ready are both 1 in the same cycle.
REQ-016 Ready outputs SHALL be combinational from state, valids and the round-robin pointer.
REQ-017 At most one ready output SHALL be high per cycle.
REQ-018 When only one requester is valid in RUN, that requester SHALL get ready=1 in the same cycle.
REQ-019 When both requesters are valid in RUN, the grant SHALL go to the requester not granted last.
REQ-020 The round-robin pointer SHALL update only on a transfer.
REQ-021 A transfer in cycle N SHALL drive arb2rf_rd_wr_req_o=1 with the registered address and data in cycle N+1 (latency 1).
REQ-022 Without a transfer, arb2rf_rd_wr_req_o SHALL be 0 in the next cycle; address and data hold their last values.
REQ-023 A transfer with address 0 SHALL be accepted, but arb2rf_rd_wr_req_o SHALL stay 0 for it (x0 suppression); the pointer still updates.
REQ-024 Requesters SHALL hold valid, addr and data stable until ready; the block does not buffer unaccepted requests.
REQ-025 In CLEAR, an ADDR_W-bit counter SHALL step from 1 to NUM_REGS-1, issuing one write of data 0 per cycle with arb2rf_rd_wr_req_o=1.
REQ-026 After the write to NUM_REGS-1, the FSM SHALL enter RUN.
REQ-027 init_done_o SHALL be registered and go to 1 in the first RUN cycle, staying 1 until reset.

Reset
REQ-028 Asserting reset (low) SHALL asynchronously set arb2rf_rd_wr_req_o=0, arb2rf_rd_addr_o=0, arb2rf_rd_data_o=0, init_done_o=0 and the clear counter to 1.
REQ-029 Asserting reset SHALL also point the round-robin pointer so that the ALU wins the first tie.
REQ-030 Reset asserted during CLEAR or RUN SHALL abort the activity; any pending output write is dropped and the clear sequence restarts from address 1 after release.
REQ-031 While reset is low, both ready outputs SHALL be 0.

Configuration
REQ-032 Macro RF_WB_CLEAR_EN defined: the FSM SHALL reset to CLEAR and perform the sequence of REQ-025 to REQ-027.
REQ-033 Macro RF_WB_CLEAR_EN undefined: the FSM SHALL reset to RUN, CLEAR logic SHALL be absent, and init_done_o SHALL go to 1 on the first clk edge after reset release.

Structure
REQ-034 Package rf_ctrl_pkg SHALL hold the FSM state enum (CLEAR, RUN), the requester-id enum (REQ_ALU, REQ_LSU), and the DATA_W/ADDR_W/NUM_REGS defaults.
REQ-035 Sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant and pointer; rf_wb_arbiter instantiates it once.

Verification
REQ-036 With RF_WB_CLEAR_EN defined, release reset -> wr_req=1 for 31 consecutive cycles, addr 1..31, data 0, both readys 0, then init_done_o=1.
REQ-037 In RUN, ALU-only valid with addr 5, data 0xDEADBEEF -> alu_wb_ready_o=1 the same cycle; next cycle wr_req=1, addr=5, data=0xDEADBEEF.
REQ-038 Both requesters valid for 4 cycles (ALU addr 3, LSU addr 7) -> grants ALU, LSU, ALU, LSU; writes to 3, 7, 3, 7, each one cycle after its grant.
REQ-039 LSU valid with addr 0, data 0x1234 -> lsu_wb_ready_o=1, wr_req stays 0, next tie goes to ALU.
REQ-040 Assert reset at clear address 10, release -> clear restarts at addr 1, 31 writes total, init_done_o=0 until done.
REQ-041 With RF_WB_CLEAR_EN undefined -> init_done_o=1 one cycle after reset release, no zero writes, ALU request accepted immediately.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package rf_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 is the ALU request, bit 1 the LSU request.
module rr_arbiter2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    // A grant is only ever issued to a valid requester, so every grant is a transfer.
    if (gnt_o[0]) begin
      last_d = REQ_ALU;
    end else if (gnt_o[1]) begin
      last_d = REQ_LSU;
    end
  end

  // Pretend the LSU won last so the ALU takes the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter between ALU and LSU with optional zeroing pass.
// Build option: define RF_WB_CLEAR_EN to clear registers 1..NUM_REGS-1 after reset.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_wb_valid_i,
  input  logic [ADDR_W-1:0] alu_wb_addr_i,
  input  logic [DATA_W-1:0] alu_wb_data_i,
  output logic              alu_wb_ready_o,
  input  logic              lsu_wb_valid_i,
  input  logic [ADDR_W-1:0] lsu_wb_addr_i,
  input  logic [DATA_W-1:0] lsu_wb_data_i,
  output logic              lsu_wb_ready_o,
  output logic              arb2rf_rd_wr_req_o,
  output logic [ADDR_W-1:0] arb2rf_rd_addr_o,
  output logic [DATA_W-1:0] arb2rf_rd_data_o,
  output logic              init_done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

`ifdef RF_WB_CLEAR_EN
  localparam rf_state_e RST_STATE = CLEAR;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`else
  localparam rf_state_e RST_STATE = RUN;
`endif

  rf_state_e         state_q, state_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              init_done_q, init_done_d;

  logic              run_en;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Reset is folded in so the readys stay low while reset is held, even in RUN.
  assign run_en = reset && (state_q == RUN);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en_i  (run_en),
    .req_i ({lsu_wb_valid_i, alu_wb_valid_i}),
    .gnt_o (gnt)
  );

  assign alu_wb_ready_o = gnt[0];
  assign lsu_wb_ready_o = gnt[1];

  assign sel_addr = gnt[1] ? lsu_wb_addr_i : alu_wb_addr_i;
  assign sel_data = gnt[1] ? lsu_wb_data_i : alu_wb_data_i;

  always_comb begin
    state_d  = state_q;
    wr_req_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
`ifdef RF_WB_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      wr_req_d = 1'b1;
      addr_d   = clr_cnt_q;
      data_d   = '0;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end else
`endif
    if (gnt != 2'b00) begin
      addr_d   = sel_addr;
      data_d   = sel_data;
      // x0 is hard-wired zero; addresses past the last register do not exist.
      wr_req_d = (sel_addr != '0) && (sel_addr <= LAST_ADDR);
    end
    init_done_d = init_done_q | (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RST_STATE;
      wr_req_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
`ifdef RF_WB_CLEAR_EN
      clr_cnt_q   <= ADDR_W'(1);
`endif
    end else begin
      state_q     <= state_d;
      wr_req_q    <= wr_req_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
`ifdef RF_WB_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  assign arb2rf_rd_wr_req_o = wr_req_q;
  assign arb2rf_rd_addr_o   = addr_q;
  assign arb2rf_rd_data_o   = data_q;
  assign init_done_o        = init_done_q;

endmodule
